c432_key_loader: RTL

Serial key loader sitting directly upstream of the locked c432 netlist. It receives a parity-protected key frame over a bit-serial valid/ready link, checks it, and commits it atomically to a held key register that drives the netlist's mux-lock inputs (p1–p4) and XOR-lock inputs (X_1–X_6). Repeated bad frames lock the block out until reset, so the netlist never sees a partial or corrupted key.

---
 rtl/c432_key_pkg.sv | 27 ++
 rtl/c432_key_sipo.sv | 37 +++
 rtl/c432_key_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/c432_key_pkg.sv
// Shared constants, state encoding and parity helper for the c432 key loader.
package c432_key_pkg;

    localparam int unsigned KEY_W_DEF    = 10;
    localparam int unsigned MAX_FAIL_DEF = 3;

    // Key field placement inside key_q
    localparam int unsigned P_LSB = 0;
    localparam int unsigned P_W   = 4;
    localparam int unsigned X_LSB = 4;
    localparam int unsigned X_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_ARMED,
        S_ERROR,
        S_LOCKED
    } state_e;

    // Returns 0 when the number of ones in v is even (frame parity good).
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/c432_key_sipo.sv
// Serial-in shadow register with bit counter and last-bit detect.
module c432_key_sipo
    import c432_key_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             sdata,
    output logic [KEY_W:0]   shadow,
    output logic             frame_done_c
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 2);

    logic [CNT_W-1:0] bit_cnt;

    // Shift accepted bits in from the LSB and count them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shadow  <= {shadow[KEY_W-1:0], sdata};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // High when the bit being accepted now completes the frame
    assign frame_done_c = shift_en && (bit_cnt == CNT_W'(KEY_W));

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader: parity-checked, atomically committed key for the locked c432.
module c432_key_loader
    import c432_key_pkg::*;
#(
    parameter int unsigned KEY_W    = KEY_W_DEF,
    parameter int unsigned MAX_FAIL = MAX_FAIL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sdata,
    input  logic             svalid,
    output logic             sready,
    output logic [P_W-1:0]   p,
    output logic [X_W-1:0]   x,
    output logic             armed,
    output logic             busy,
    output logic             err,
    output logic             locked
);

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [2:0]       fail_q, fail_d;
    logic             committed_q, committed_d;
    logic             err_d;
    logic             sipo_clear_c;
    logic             accept_c;
    logic [KEY_W:0]   shadow;
    logic             frame_done_c;

    assign accept_c = svalid && sready;

    c432_key_sipo #(
        .KEY_W (KEY_W)
    ) u_sipo (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (sipo_clear_c),
        .shift_en     (accept_c),
        .sdata        (sdata),
        .shadow       (shadow),
        .frame_done_c (frame_done_c)
    );

    // Next-state, key commit and failure accounting
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        fail_d       = fail_q;
        committed_d  = committed_q;
        err_d        = err;
        sipo_clear_c = 1'b0;
        case (state_q)
            S_IDLE, S_ARMED, S_ERROR: begin
                if (start) begin
                    state_d      = S_SHIFT;
                    sipo_clear_c = 1'b1;
                    err_d        = 1'b0;
                end
            end
            S_SHIFT: begin
                if (frame_done_c) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!even_parity(32'(shadow))) begin
                    key_d       = shadow[KEY_W:1];
                    fail_d      = 3'd0;
                    committed_d = 1'b1;
                    state_d     = S_ARMED;
                end else begin
                    err_d  = 1'b1;
                    fail_d = (fail_q == 3'(MAX_FAIL)) ? fail_q : fail_q + 3'd1;
                    if (fail_d == 3'(MAX_FAIL)) begin
                        state_d = S_LOCKED;
                        key_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LOCKED: begin
                key_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, key and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            fail_q      <= 3'd0;
            committed_q <= 1'b0;
            err         <= 1'b0;
            sready      <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            fail_q      <= fail_d;
            committed_q <= committed_d;
            err         <= err_d;
            sready      <= (state_d == S_SHIFT);
            busy        <= (state_d == S_SHIFT) || (state_d == S_CHECK);
            locked      <= (state_d == S_LOCKED);
            armed       <= (state_d == S_ARMED) ||
                           (committed_d && ((state_d == S_SHIFT) ||
                                            (state_d == S_CHECK) ||
                                            (state_d == S_ERROR)));
        end
    end

    assign p = key_q[P_LSB +: P_W];
    assign x = key_q[X_LSB +: X_W];

endmodule
